// File: rtl/issue_select.sv
// Age-ordered issue selector: oldest eligible entry per station, fixed priority with starvation promotion across stations.
// Latency: rs_ren/rs_raddr combinational in the grant cycle; descriptor registered one cycle later.
// Backpressure: no grant while out_valid && ~out_ready (descriptor and starve counters hold); flush drops the descriptor.
module issue_select #(
    parameter int NUM_RS       = 4,
    parameter int DEPTH        = 8,
    parameter int SEQ_W        = 6,
    parameter int NUM_EU       = 5,
    parameter int EUID_W       = 3,
    parameter int STARVE_LIMIT = 7,
    localparam int IDX_W       = $clog2(DEPTH),
    localparam int RS_W        = $clog2(NUM_RS),
    localparam int STARVE_W    = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [SEQ_W-1:0]               rob_head,
    input  logic [NUM_EU-1:0]              eu_ready,
    input  logic [NUM_RS*DEPTH-1:0]        rs_req,
    input  logic [NUM_RS*DEPTH*SEQ_W-1:0]  rs_age,
    input  logic [NUM_RS*DEPTH*EUID_W-1:0] rs_euid,
    output logic [NUM_RS-1:0]              rs_ren,
    output logic [NUM_RS*IDX_W-1:0]        rs_raddr,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [RS_W-1:0]                out_rs,
    output logic [IDX_W-1:0]               out_idx,
    output logic [EUID_W-1:0]              out_euid,
    output logic [SEQ_W-1:0]               out_age
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [2**EUID_W-1:0]       eu_mask;
    logic [NUM_RS*DEPTH-1:0]    elig;
    logic [SEQ_W-1:0]           ent_off [NUM_RS*DEPTH];

    logic [NUM_RS-1:0]          st_vld;
    logic [IDX_W-1:0]           st_idx  [NUM_RS];
    logic [SEQ_W-1:0]           st_off  [NUM_RS];
    logic [SEQ_W-1:0]           st_age  [NUM_RS];
    logic [EUID_W-1:0]          st_euid [NUM_RS];

    logic [STARVE_W-1:0]        starve_cnt [NUM_RS];
    logic [NUM_RS-1:0]          starved;
    logic                       found;
    logic                       can_accept;
    logic                       grant;
    logic [RS_W-1:0]            gnt_rs;

    // EU ids beyond NUM_EU map to a zero mask bit and are never eligible.
    always_comb begin
        eu_mask = '0;
        for (int e = 0; e < NUM_EU; e++) begin
            eu_mask[e] = eu_ready[e];
        end
    end

    always_comb begin
        for (int e = 0; e < NUM_RS*DEPTH; e++) begin
            elig[e]    = rs_req[e] && eu_mask[rs_euid[e*EUID_W +: EUID_W]];
            ent_off[e] = rs_age[e*SEQ_W +: SEQ_W] - rob_head;
        end
    end

    // Ascending scan with strict compare: on equal age the lower index is kept.
    always_comb begin
        for (int r = 0; r < NUM_RS; r++) begin
            st_vld[r]  = 1'b0;
            st_idx[r]  = '0;
            st_off[r]  = '1;
            st_age[r]  = '0;
            st_euid[r] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (elig[r*DEPTH+i] && (!st_vld[r] || ent_off[r*DEPTH+i] < st_off[r])) begin
                    st_vld[r]  = 1'b1;
                    st_idx[r]  = IDX_W'(i);
                    st_off[r]  = ent_off[r*DEPTH+i];
                    st_age[r]  = rs_age[(r*DEPTH+i)*SEQ_W +: SEQ_W];
                    st_euid[r] = rs_euid[(r*DEPTH+i)*EUID_W +: EUID_W];
                end
            end
        end
    end

    assign can_accept = ~out_valid | out_ready;

    always_comb begin
        starved = '0;
        for (int r = 0; r < NUM_RS; r++) begin
            starved[r] = st_vld[r] && (starve_cnt[r] == LIMIT);
        end
        found  = 1'b0;
        gnt_rs = '0;
        for (int r = 0; r < NUM_RS; r++) begin
            if (!found && ((|starved) ? starved[r] : st_vld[r])) begin
                found  = 1'b1;
                gnt_rs = RS_W'(r);
            end
        end
        grant    = rst_n && can_accept && !flush && (|st_vld);
        rs_ren   = '0;
        rs_raddr = '0;
        for (int r = 0; r < NUM_RS; r++) begin
            if (grant && gnt_rs == RS_W'(r)) begin
                rs_ren[r]                    = 1'b1;
                rs_raddr[r*IDX_W +: IDX_W]   = st_idx[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_rs    <= '0;
            out_idx   <= '0;
            out_euid  <= '0;
            out_age   <= '0;
            for (int r = 0; r < NUM_RS; r++) begin
                starve_cnt[r] <= '0;
            end
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (grant) begin
                out_valid <= 1'b1;
                out_rs    <= gnt_rs;
                out_idx   <= st_idx[gnt_rs];
                out_euid  <= st_euid[gnt_rs];
                out_age   <= st_age[gnt_rs];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Counters only advance in cycles where a grant was possible.
            for (int r = 0; r < NUM_RS; r++) begin
                if (flush) begin
                    starve_cnt[r] <= '0;
                end else if (can_accept) begin
                    if (st_vld[r] && !(grant && gnt_rs == RS_W'(r))) begin
                        starve_cnt[r] <= (starve_cnt[r] == LIMIT) ? LIMIT : starve_cnt[r] + 1'b1;
                    end else begin
                        starve_cnt[r] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/issue_select.md
Name: issue_select

Overview:
- Parametrised age-ordered issue selector for the OoO backend.
- Takes request vectors from NUM_RS reservation stations and picks the oldest eligible entry in each station using ROB-relative age.
- Arbitrates across stations with fixed priority plus starvation promotion.
- Drives the RS read enable/address and holds a registered issue descriptor with a valid/ready handshake toward the register-read/EU stage.

Parameters:
- NUM_RS, 4, number of reservation stations; index 0 has highest base priority.
- DEPTH, 8, entries per station; IDX_W = $clog2(DEPTH).
- SEQ_W, 6, ROB sequence tag width.
- NUM_EU, 5, number of execution units.
- EUID_W, 3, EU id width.
- STARVE_LIMIT, 7, consecutive lost-arbitration cycles before a station is promoted; STARVE_W = $clog2(STARVE_LIMIT+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush (branch mispredict)
- rob_head  in  SEQ_W  sequence tag of the oldest in-flight instruction
- eu_ready  in  NUM_EU  per-EU accept capability
- rs_req  in  NUM_RS*DEPTH  entry woken up and valid
- rs_age  in  NUM_RS*DEPTH*SEQ_W  entry ROB tag
- rs_euid  in  NUM_RS*DEPTH*EUID_W  target EU of entry
- rs_ren  out  NUM_RS  one-hot-or-zero read/dequeue strobe
- rs_raddr  out  NUM_RS*IDX_W  selected entry per station; 0 when that station is not granted
- out_valid  out  1  registered issue descriptor valid
- out_ready  in  1  downstream consumes descriptor
- out_rs  out  $clog2(NUM_RS)  station of issued entry
- out_idx  out  IDX_W  entry index
- out_euid  out  EUID_W  target EU
- out_age  out  SEQ_W  ROB tag

Behaviour:
- Reset (rst_n=0, async): out_valid=0; out_rs, out_idx, out_euid, out_age=0; all starve_cnt=0. rs_ren is combinational, and is 0 during reset.
- Eligible entry: rs_req[r][i] && eu_ready[rs_euid[r][i]]. An euid >= NUM_EU is never eligible.
- Age: off = (rs_age - rob_head) mod 2^SEQ_W, computed as an unsigned SEQ_W-bit subtract so wrap is correct. Smaller off is older.
- Per-station pick: the eligible entry with minimum off. On equal off, the lower index wins.
- can_accept = ~out_valid | out_ready.
- Grant condition: can_accept && ~flush && at least one station has an eligible entry. Otherwise rs_ren=0.
- Cross-station arbitration:
  - A station is starved when starve_cnt == STARVE_LIMIT.
  - If any station with an eligible entry is starved, the lowest-index starved station wins.
  - Otherwise the lowest-index eligible station wins.
- Grant is combinational in cycle t: rs_ren[r]=1 and rs_raddr[r]=idx. At the t→t+1 edge the output register loads: out_valid=1, out_rs=r, out_idx, out_euid, out_age.
- Latency: one cycle from request to out_valid.
- Output register:
  - Holds its value while out_valid && ~out_ready.
  - On out_ready with no new grant, it clears (out_valid=0).
  - Back-to-back grants every cycle are allowed while out_ready=1.
- Starvation counter per station, updated only when can_accept && ~flush:
  - Station had an eligible entry and lost → counter increments, saturating at STARVE_LIMIT.
  - Station won, or had no eligible entry → counter resets to 0.
  - can_accept=0 → counters hold.
- Flush (synchronous, highest priority):
  - No grant that cycle.
  - out_valid←0 next edge, even if out_ready=0.
  - All starve_cnt←0.
- Simultaneous out_ready and a new grant: the new descriptor replaces the old one; no bubble.
- rob_head may change every cycle; age comparison uses the current-cycle value only.

Test Plan:
- Age wrap: rob_head=62; RS1 entries 2 (age 63) and 5 (age 1) requesting; eu_ready all 1 → rs_ren=4'b0010, rs_raddr[1]=2; next cycle out_valid=1, out_idx=2, out_age=63.
- EU masking: RS0 entry 0 has euid=3 and eu_ready[3]=0; RS2 entry 4 has euid=1 → RS2 granted, idx 4; after eu_ready[3] rises, RS0 entry 0 is granted next.
- Starvation: RS0 and RS3 request continuously, out_ready=1 → RS0 wins 7 cycles, RS3 starve_cnt reaches 7, RS3 wins on the 8th cycle, then RS3 count resets to 0.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles while requests are pending → rs_ren=0, outputs stable, starve counters unchanged; when out_ready=1, a grant occurs in the same cycle with no bubble.
- Flush: out_valid=1, out_ready=0, flush=1 with requests pending → rs_ren=0; next cycle out_valid=0 and all starve_cnt=0.
- Reset mid-operation: assert rst_n=0 asynchronously between edges while out_valid=1 → out_valid=0 immediately, counters 0; after release, first grant is valid one cycle later.
